// File: rtl/rr_tenure_sched.sv
// -----------------------------------------------------------------------------
// rr_tenure_sched
//
// Round-robin scheduler that shares one resource between N requesting
// masters. An owner keeps its grant while it holds its request. When the
// tenure limit is reached and another master is waiting, the owner is
// preempted. A programmable idle gap separates successive owners.
//
// Parameters:
//   N            number of masters (2..16)
//   MAX_HOLD     grant cycles before preemption is allowed; 0 = unlimited
//   HANDOVER_GAP idle cycles with no grant between owners (0..7)
//
// Ports:
//   i_clk        clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_req        per-master level request, held until the master is done
//   o_gnt        one-hot (or zero) registered grant
//   o_gnt_id     index of the current owner; holds its value when idle
//   o_gnt_valid  OR of o_gnt, registered alongside it
//   o_preempt    one-cycle pulse when an owner is forcibly released
//   o_hold_cnt   cycles the current owner has held the grant (saturating)
//
// Optional build macro:
//   RR_TENURE_SCHED_ASSERT_EN  compiles the embedded protocol checker
//   (rr_tenure_sched_chk). Without it no checker code exists and the
//   scheduler behaves identically.
// -----------------------------------------------------------------------------

`ifdef RR_TENURE_SCHED_ASSERT_EN
// Protocol checker bound inside the scheduler when the macro is defined.
module rr_tenure_sched_chk #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input logic           i_clk,
  input logic           i_rst_n,
  input logic [N-1:0]   i_req,
  input logic [N-1:0]   i_gnt,
  input logic [IDW-1:0] i_gnt_id,
  input logic           i_gnt_valid,
  input logic           i_preempt,
  input logic           i_in_gap
);

  logic [N-1:0] r_req_q;
  logic [N-1:0] r_gnt_q;

  // Delayed copies so a new grant can be checked against the requests of its grant edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_req_q <= '0;
      r_gnt_q <= '0;
    end else begin
      r_req_q <= i_req;
      r_gnt_q <= i_gnt;
    end
  end

  a_onehot0: assert property (@(posedge i_clk) disable iff (!i_rst_n) $onehot0(i_gnt))
    else $error("rr_tenure_sched: grant is not one-hot-or-zero (%b)", i_gnt);

  a_rst_gnt: assert property (@(posedge i_clk) !i_rst_n |-> (i_gnt == '0))
    else $error("rr_tenure_sched: grant active during reset");

  a_gnt_req: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      (i_gnt_valid && (i_gnt != r_gnt_q)) |-> r_req_q[i_gnt_id])
    else $error("rr_tenure_sched: grant %0d issued without a request", i_gnt_id);

  a_gap_idle: assert property (@(posedge i_clk) disable iff (!i_rst_n) i_in_gap |-> (i_gnt == '0))
    else $error("rr_tenure_sched: grant issued during handover gap");

  a_preempt_pulse: assert property (@(posedge i_clk) disable iff (!i_rst_n) i_preempt |=> !i_preempt)
    else $error("rr_tenure_sched: preempt high for two consecutive cycles");

endmodule
`else
// Checker module is not compiled in the default build.
`endif

module rr_tenure_sched #(
  parameter  int N            = 4,
  parameter  int MAX_HOLD     = 16,
  parameter  int HANDOVER_GAP = 1,
  localparam int IDW          = (N > 1) ? $clog2(N) : 1,
  localparam int HW           = ($clog2(MAX_HOLD + 1) > 1) ? $clog2(MAX_HOLD + 1) : 1
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic [N-1:0]   i_req,
  output logic [N-1:0]   o_gnt,
  output logic [IDW-1:0] o_gnt_id,
  output logic           o_gnt_valid,
  output logic           o_preempt,
  output logic [HW-1:0]  o_hold_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  // With unlimited tenure the counter simply saturates at its width maximum.
  localparam int             HOLD_SAT_I = (MAX_HOLD != 0) ? MAX_HOLD : ((1 << HW) - 1);
  localparam logic [HW-1:0]  HOLD_SAT   = HOLD_SAT_I[HW-1:0];
  localparam logic [HW-1:0]  HOLD_ONE   = HW'(1);
  // The gap counter is loaded with GAP-1 so the state lasts exactly GAP cycles.
  localparam int             GAP_INIT_I = (HANDOVER_GAP > 0) ? (HANDOVER_GAP - 1) : 0;
  localparam logic [2:0]     GAP_INIT   = GAP_INIT_I[2:0];
  localparam bit             GAP_EN     = (HANDOVER_GAP > 0);
  localparam bit             TENURE_EN  = (MAX_HOLD != 0);
  // Last owner starts at N-1 so master 0 is first in line after reset.
  localparam logic [IDW-1:0] LAST_INIT  = IDW'(N - 1);

  state_t         r_state;
  logic [N-1:0]   r_gnt;
  logic           r_gnt_valid;
  logic [IDW-1:0] r_gnt_id;
  logic [IDW-1:0] r_last_id;
  logic           r_preempt;
  logic [HW-1:0]  r_hold_cnt;
  logic [2:0]     r_gap_cnt;

  logic [N-1:0]   w_req_eff;
  logic           w_found;
  logic [IDW-1:0] w_win;
  logic           w_others;
  logic           w_release;
  logic           w_expire;

  function automatic logic [N-1:0] f_onehot(input logic [IDW-1:0] idx);
    logic [N-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Round-robin search from last_id+1. The current owner is masked out so that
  // on preemption it can only win last; in IDLE/GAP r_gnt is zero so the mask is inert.
  // Walking from lowest to highest priority lets the highest-priority hit overwrite.
  always_comb begin
    logic [IDW-1:0] w_k;
    w_req_eff = i_req & ~r_gnt;
    w_found   = 1'b0;
    w_win     = '0;
    w_k       = '0;
    for (int i = N - 1; i >= 0; i--) begin
      w_k     = IDW'((int'(r_last_id) + 1 + i) % N);
      w_found = w_found | w_req_eff[w_k];
      w_win   = w_req_eff[w_k] ? w_k : w_win;
    end
  end

  // Release and tenure-expiry conditions for the current owner.
  always_comb begin
    w_others  = |(i_req & ~r_gnt);
    w_release = ~i_req[r_gnt_id];
    w_expire  = TENURE_EN && (r_hold_cnt == HOLD_SAT) && w_others;
  end

  // Scheduler FSM with all outputs registered.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_gnt       <= '0;
      r_gnt_valid <= 1'b0;
      r_gnt_id    <= '0;
      r_last_id   <= LAST_INIT;
      r_preempt   <= 1'b0;
      r_hold_cnt  <= '0;
      r_gap_cnt   <= 3'd0;
    end else begin
      r_preempt <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state     <= S_GRANT;
            r_gnt       <= f_onehot(w_win);
            r_gnt_valid <= 1'b1;
            r_gnt_id    <= w_win;
            r_last_id   <= w_win;
            r_hold_cnt  <= HOLD_ONE;
          end else begin
            r_gnt       <= '0;
            r_gnt_valid <= 1'b0;
            r_hold_cnt  <= '0;
          end
        end

        S_GRANT: begin
          if (w_release || w_expire) begin
            // A release that coincides with expiry is an ordinary release.
            r_preempt <= ~w_release;
            if (GAP_EN) begin
              r_state     <= S_GAP;
              r_gap_cnt   <= GAP_INIT;
              r_gnt       <= '0;
              r_gnt_valid <= 1'b0;
              r_hold_cnt  <= '0;
            end else if (w_found) begin
              // Zero gap: hand the grant straight to the next winner.
              r_state     <= S_GRANT;
              r_gnt       <= f_onehot(w_win);
              r_gnt_valid <= 1'b1;
              r_gnt_id    <= w_win;
              r_last_id   <= w_win;
              r_hold_cnt  <= HOLD_ONE;
            end else begin
              r_state     <= S_IDLE;
              r_gnt       <= '0;
              r_gnt_valid <= 1'b0;
              r_hold_cnt  <= '0;
            end
          end else begin
            if (r_hold_cnt != HOLD_SAT) begin
              r_hold_cnt <= r_hold_cnt + HOLD_ONE;
            end else begin
              r_hold_cnt <= r_hold_cnt;
            end
          end
        end

        S_GAP: begin
          if (r_gap_cnt == 3'd0) begin
            if (w_found) begin
              r_state     <= S_GRANT;
              r_gnt       <= f_onehot(w_win);
              r_gnt_valid <= 1'b1;
              r_gnt_id    <= w_win;
              r_last_id   <= w_win;
              r_hold_cnt  <= HOLD_ONE;
            end else begin
              r_state     <= S_IDLE;
              r_gnt       <= '0;
              r_gnt_valid <= 1'b0;
              r_hold_cnt  <= '0;
            end
          end else begin
            r_gap_cnt <= r_gap_cnt - 3'd1;
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_gnt       <= '0;
          r_gnt_valid <= 1'b0;
          r_hold_cnt  <= '0;
        end
      endcase
    end
  end

  assign o_gnt       = r_gnt;
  assign o_gnt_id    = r_gnt_id;
  assign o_gnt_valid = r_gnt_valid;
  assign o_preempt   = r_preempt;
  assign o_hold_cnt  = r_hold_cnt;

`ifdef RR_TENURE_SCHED_ASSERT_EN
  logic w_in_gap;
  assign w_in_gap = (r_state == S_GAP);

  rr_tenure_sched_chk #(
    .N   (N),
    .IDW (IDW)
  ) u_chk (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_req       (i_req),
    .i_gnt       (r_gnt),
    .i_gnt_id    (r_gnt_id),
    .i_gnt_valid (r_gnt_valid),
    .i_preempt   (r_preempt),
    .i_in_gap    (w_in_gap)
  );
`else
  // No checker instance in the default build.
`endif

endmodule

// File: tb/tb_rr_tenure_sched.sv
// -----------------------------------------------------------------------------
// tb_rr_tenure_sched
//
// Directed bench for rr_tenure_sched. Three instances cover the default
// configuration (A: MAX_HOLD=16, GAP=1), a short tenure (B: MAX_HOLD=4,
// GAP=1) and zero handover gap (C: MAX_HOLD=16, GAP=0). Each step drives a
// request pattern, pushes the hand-derived expected outputs to a scoreboard
// queue, waits one rising edge and compares the DUT against the popped entry.
// -----------------------------------------------------------------------------
module tb_rr_tenure_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req_a, req_b, req_c;
  logic [3:0] gnt_a, gnt_b, gnt_c;
  logic [1:0] id_a, id_b, id_c;
  logic       val_a, val_b, val_c;
  logic       pre_a, pre_b, pre_c;
  logic [4:0] hold_a;
  logic [2:0] hold_b;
  logic [4:0] hold_c;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          sel;
    string       tag;
    logic [3:0]  gnt;
    logic [31:0] id;
    logic        pre;
    logic [31:0] hold;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  rr_tenure_sched #(.N(4), .MAX_HOLD(16), .HANDOVER_GAP(1)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req_a), .o_gnt(gnt_a), .o_gnt_id(id_a),
    .o_gnt_valid(val_a), .o_preempt(pre_a), .o_hold_cnt(hold_a));

  rr_tenure_sched #(.N(4), .MAX_HOLD(4), .HANDOVER_GAP(1)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req_b), .o_gnt(gnt_b), .o_gnt_id(id_b),
    .o_gnt_valid(val_b), .o_preempt(pre_b), .o_hold_cnt(hold_b));

  rr_tenure_sched #(.N(4), .MAX_HOLD(16), .HANDOVER_GAP(0)) dut_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req_c), .o_gnt(gnt_c), .o_gnt_id(id_c),
    .o_gnt_valid(val_c), .o_preempt(pre_c), .o_hold_cnt(hold_c));

  function automatic logic [3:0] oh(input int m);
    logic [3:0] v;
    v = 4'b0000;
    v[m[1:0]] = 1'b1;
    return v;
  endfunction

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_check();
    exp_t        e;
    logic [3:0]  g;
    logic [31:0] id, h;
    logic        v, p;
    e = sb.pop_front();
    case (e.sel)
      0: begin g = gnt_a; id = {30'd0, id_a}; v = val_a; p = pre_a; h = {27'd0, hold_a}; end
      1: begin g = gnt_b; id = {30'd0, id_b}; v = val_b; p = pre_b; h = {29'd0, hold_b}; end
      default: begin g = gnt_c; id = {30'd0, id_c}; v = val_c; p = pre_c; h = {27'd0, hold_c}; end
    endcase
    cmp({e.tag, ".gnt"},     {28'd0, g}, {28'd0, e.gnt});
    cmp({e.tag, ".valid"},   {31'd0, v}, {31'd0, |e.gnt});
    cmp({e.tag, ".gnt_id"},  id,         e.id);
    cmp({e.tag, ".preempt"}, {31'd0, p}, {31'd0, e.pre});
    cmp({e.tag, ".hold"},    h,          e.hold);
  endtask

  task automatic push_exp(input int sel, input logic [3:0] g, input int id,
                          input logic p, input int h, input string tag);
    exp_t e;
    e.sel = sel; e.tag = tag; e.gnt = g; e.id = id; e.pre = p; e.hold = h;
    sb.push_back(e);
  endtask

  // Drive a request pattern, expect the outputs after the next rising edge.
  task automatic step(input int sel, input logic [3:0] r, input logic [3:0] g, input int id,
                      input logic p, input int h, input string tag);
    case (sel)
      0: req_a = r;
      1: req_b = r;
      default: req_c = r;
    endcase
    push_exp(sel, g, id, p, h, tag);
    @(posedge clk);
    #1;
    pop_check();
  endtask

  // Compare immediately, without waiting for a clock edge.
  task automatic check_now(input int sel, input logic [3:0] g, input int id,
                           input logic p, input int h, input string tag);
    push_exp(sel, g, id, p, h, tag);
    pop_check();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_a = 4'b0000;
    req_b = 4'b0000;
    req_c = 4'b0000;
    @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) check_now(s, 4'b0000, 0, 1'b0, 0, $sformatf("rst.dut%0d", s));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] r;
    rst_n = 1'b0;
    req_a = 4'b0000;
    req_b = 4'b0000;
    req_c = 4'b0000;

    // Test 1: single master grant, release, gap, idle; request raised in the gap.
    do_reset();
    step(0, 4'b0001, 4'b0001, 0, 1'b0, 1, "t1.grant");
    step(0, 4'b0001, 4'b0001, 0, 1'b0, 2, "t1.hold2");
    step(0, 4'b0000, 4'b0000, 0, 1'b0, 0, "t1.release");
    step(0, 4'b0000, 4'b0000, 0, 1'b0, 0, "t1.gap_end");
    step(0, 4'b0000, 4'b0000, 0, 1'b0, 0, "t1.idle");
    step(0, 4'b0010, 4'b0010, 1, 1'b0, 1, "t1.grant1");
    step(0, 4'b0000, 4'b0000, 1, 1'b0, 0, "t1.rel1");
    step(0, 4'b0001, 4'b0001, 0, 1'b0, 1, "t1.gap_req");
    step(0, 4'b0000, 4'b0000, 0, 1'b0, 0, "t1.rel0");

    // Test 2: all request, each owner leaves after 3 cycles; order 0,1,2,3,0.
    do_reset();
    r = 4'b1111;
    for (int m = 0; m < 4; m++) begin
      for (int k = 1; k <= 3; k++)
        step(0, r, oh(m), m, 1'b0, k, $sformatf("t2.m%0d.h%0d", m, k));
      r = r & ~oh(m);
      if (m == 3) r = 4'b0001;
      step(0, r, 4'b0000, m, 1'b0, 0, $sformatf("t2.m%0d.gap", m));
    end
    step(0, r, 4'b0001, 0, 1'b0, 1, "t2.wrap0");
    step(0, 4'b0000, 4'b0000, 0, 1'b0, 0, "t2.rel");

    // Test 3: MAX_HOLD=4, two masters held; alternating preemption.
    do_reset();
    for (int rnd = 0; rnd < 3; rnd++) begin
      int m;
      m = rnd % 2;
      for (int k = 1; k <= 4; k++)
        step(1, 4'b0011, oh(m), m, 1'b0, k, $sformatf("t3.r%0d.h%0d", rnd, k));
      step(1, 4'b0011, 4'b0000, m, 1'b1, 0, $sformatf("t3.r%0d.preempt", rnd));
    end
    step(1, 4'b0000, 4'b0000, 0, 1'b0, 0, "t3.idle");

    // Test 4: lone owner saturates at MAX_HOLD, preempted once another arrives.
    do_reset();
    for (int k = 1; k <= 10; k++)
      step(1, 4'b0100, 4'b0100, 2, 1'b0, (k < 4) ? k : 4, $sformatf("t4.h%0d", k));
    step(1, 4'b0101, 4'b0000, 2, 1'b1, 0, "t4.preempt");
    step(1, 4'b0101, 4'b0001, 0, 1'b0, 1, "t4.gnt0");
    step(1, 4'b0101, 4'b0001, 0, 1'b0, 2, "t4.hold2");

    // Test 5: zero gap, direct one-hot to one-hot switch, then idle.
    do_reset();
    step(2, 4'b0110, 4'b0010, 1, 1'b0, 1, "t5.gnt1");
    step(2, 4'b0110, 4'b0010, 1, 1'b0, 2, "t5.hold2");
    step(2, 4'b0100, 4'b0100, 2, 1'b0, 1, "t5.switch");
    step(2, 4'b0100, 4'b0100, 2, 1'b0, 2, "t5.hold2b");
    step(2, 4'b0000, 4'b0000, 2, 1'b0, 0, "t5.idle");
    step(2, 4'b0000, 4'b0000, 2, 1'b0, 0, "t5.idle2");

    // Test 5b: zero gap preemption at MAX_HOLD=16 switches directly.
    do_reset();
    for (int k = 1; k <= 16; k++)
      step(2, 4'b0011, 4'b0001, 0, 1'b0, k, $sformatf("t5b.h%0d", k));
    step(2, 4'b0011, 4'b0010, 1, 1'b1, 1, "t5b.pre_switch");
    step(2, 4'b0011, 4'b0010, 1, 1'b0, 2, "t5b.pre_clear");

    // Test 6: asynchronous reset mid-tenure, X on req during reset, restart.
    do_reset();
    for (int k = 1; k <= 7; k++)
      step(0, 4'b1000, 4'b1000, 3, 1'b0, k, $sformatf("t6.h%0d", k));
    #3;
    rst_n = 1'b0;
    req_a = 4'bxxxx;
    #1;
    for (int s = 0; s < 3; s++) check_now(s, 4'b0000, 0, 1'b0, 0, $sformatf("t6.async.dut%0d", s));
    @(posedge clk);
    #1;
    check_now(0, 4'b0000, 0, 1'b0, 0, "t6.rst_x");
    @(negedge clk);
    req_a = 4'b1001;
    rst_n = 1'b1;
    step(0, 4'b1001, 4'b0001, 0, 1'b0, 1, "t6.first0");
    step(0, 4'b1001, 4'b0001, 0, 1'b0, 2, "t6.hold2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
